vec_result_writeback: RTL and testbench
=======================================

# vec_result_writeback

Writeback stage that takes a widened ALU result (LANES lanes of 2×ELEM_W bits each) and narrows it onto the ELEM_W-per-lane vector register-file write port. A wide result is written as two register writes: low halves to `dest`, then high halves to `dest+1`. A narrow result writes the low halves only. The block sits between the vector ALU output and the vector register file, with a valid/ready handshake on the ALU side and a stallable write port on the register-file side.

## Interface
- `LANES`, 16, number of vector lanes
- `ELEM_W`, 32, register element width; each ALU result lane is 2×ELEM_W
- `REG_AW`, 2, vector register address width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `res_valid`  in  1  ALU result present
- `res_ready`  out  1  block can accept a result this cycle
- `res_data`  in  LANES×2×ELEM_W  lane i occupies bits [2·ELEM_W·i +: 2·ELEM_W]
- `res_dest`  in  REG_AW  destination register for the low halves
- `res_wide`  in  1  1 = write low and high halves; 0 = write low halves only
- `wr_en`  out  1  register-file write request
- `wr_addr`  out  REG_AW  write address
- `wr_data`  out  LANES×ELEM_W  write data; lane i at [ELEM_W·i +: ELEM_W]
- `wr_stall`  in  1  register file cannot take the write this cycle
- `done`  out  1  one-cycle pulse when the last write of a result is accepted

## Operation
- States: IDLE, WR_LO, WR_HI.
- A transfer occurs when `res_valid && res_ready`. On transfer, capture `res_data`, `res_dest`, `res_wide` and go to WR_LO.
- WR_LO: `wr_en`=1, `wr_addr`=dest, `wr_data` lane i = captured lane i bits [ELEM_W-1:0].
  - On acceptance (`!wr_stall`): go to WR_HI if wide; otherwise the result is complete.
- WR_HI: `wr_en`=1, `wr_addr`=(dest+1) mod 2^REG_AW, `wr_data` lane i = captured lane i bits [2·ELEM_W-1:ELEM_W].
  - On acceptance the result is complete.
- When a result completes, `done`=1 in that cycle (combinational with acceptance). Next state is WR_LO if a new transfer occurs in the same cycle, else IDLE.
- `res_ready` = (state==IDLE) || (final write of the current result accepted this cycle). This allows back-to-back results with no bubble.
- While `wr_stall`=1, `wr_en`, `wr_addr` and `wr_data` hold stable. No state change.
- Address wrap: dest = 2^REG_AW−1 wraps the high write to address 0.
- Reset (any time, including mid-result):
  - state → IDLE; captured result is discarded.
  - Outputs: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `done`=0, `res_ready`=1 after release.

## Timing
- Latency from transfer to first `wr_en`: 1 cycle.
- Narrow result: 1 write cycle minimum. Wide result: 2 write cycles minimum.
- Sustained throughput with no stall:
  - all narrow: 1 result/cycle;
  - all wide: 1 result per 2 cycles.
- `res_ready` and `done` have a combinational path from `wr_stall`. All other outputs are registered.
- `wr_stall` has no effect in IDLE.

## Structure
- Shared package `vec_pkg`:
  - constants `LANES`, `ELEM_W`, `REG_AW`;
  - state enum `wb_state_t` {IDLE, WR_LO, WR_HI};
  - a lane-select function that returns the low or high half of each lane.
- One sub-module, `vec_lane_narrow`: a combinational half-select across all lanes. It is parameterised by LANES/ELEM_W, selected by a `hi` bit, and is reusable by the store path.

## Test plan
- Wide single result: lane i = {32'h1000+i, 32'h2000+i}, dest=1, no stall.
  - Expected: `wr_en` at cycles t+1 and t+2.
  - addr 1 carries lanes 32'h2000+i; addr 2 carries lanes 32'h1000+i.
  - `done` pulses at t+2.
- Narrow result, dest=3, data lane i = 64'hFFFF_FFFF_0000_000i.
  - Expected: exactly one write to addr 3 with lane i = i.
  - No write to addr 0; `done` at t+1.
- Wrap: wide result with dest=3.
  - Expected: low write to addr 3, high write to addr 0.
- Stall: `wr_stall`=1 for 3 cycles during WR_HI.
  - Expected: `wr_addr`/`wr_data` stable throughout.
  - `res_ready`=0 while stalled; `done` only in the cycle stall drops.
- Back-to-back: 4 narrow results on consecutive cycles, then 2 wide results.
  - Expected: narrow writes on 4 consecutive cycles with no bubble.
  - Wide writes as 4 consecutive writes, with `res_ready` low every other cycle.
- Reset mid-op: assert `rst_n`=0 during WR_LO of a wide result.
  - Expected: `wr_en` drops immediately (asynchronously); no high write after release.
  - `res_ready`=1 and the next result is written correctly.

Source files
------------

// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared constants, writeback state enum and lane half-select helper
package vec_pkg;
  localparam int LANES  = 16;
  localparam int ELEM_W = 32;
  localparam int REG_AW = 2;
  localparam int RES_W  = LANES * 2 * ELEM_W;
  localparam int WR_W   = LANES * ELEM_W;

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} wb_state_t;

  // Returns the low (hi=0) or high (hi=1) ELEM_W half of every wide lane.
  function automatic logic [WR_W-1:0] lane_select(input logic [RES_W-1:0] res, input logic hi);
    logic [WR_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      r[ELEM_W*i +: ELEM_W] = res[2*ELEM_W*i + (hi ? ELEM_W : 0) +: ELEM_W];
    end
    return r;
  endfunction
endpackage

// File: rtl/vec_result_writeback_if.sv
// rtl/vec_result_writeback_if.sv - ALU result handshake and register-file write port bundle
interface vec_result_writeback_if import vec_pkg::*; ();
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic [REG_AW-1:0] res_dest;
  logic              res_wide;
  logic              wr_en;
  logic [REG_AW-1:0] wr_addr;
  logic [WR_W-1:0]   wr_data;
  logic              wr_stall;
  logic              done;

  modport slave (
    input  res_valid, res_data, res_dest, res_wide, wr_stall,
    output res_ready, wr_en, wr_addr, wr_data, done
  );

  modport master (
    output res_valid, res_data, res_dest, res_wide, wr_stall,
    input  res_ready, wr_en, wr_addr, wr_data, done
  );
endinterface

// File: rtl/vec_lane_narrow.sv
// rtl/vec_lane_narrow.sv - combinational per-lane half select from a wide vector
module vec_lane_narrow #(
  parameter int LANES  = 16,
  parameter int ELEM_W = 32
) (
  input  logic [LANES*2*ELEM_W-1:0] wide_data,
  input  logic                      hi,
  output logic [LANES*ELEM_W-1:0]   narrow_data
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign narrow_data[ELEM_W*i +: ELEM_W] = hi ? wide_data[2*ELEM_W*i + ELEM_W +: ELEM_W]
                                                : wide_data[2*ELEM_W*i +: ELEM_W];
  end
endmodule

// File: rtl/vec_result_writeback.sv
// rtl/vec_result_writeback.sv - narrows a widened ALU result into one or two register-file writes
module vec_result_writeback import vec_pkg::*; (
  input logic                    clk,
  input logic                    rst_n,
  vec_result_writeback_if.slave  bus
);
  wb_state_t         state, state_nxt;
  logic [WR_W-1:0]   res_lo, res_hi, hi_q;
  logic              wide_q;
  logic [REG_AW-1:0] addr_q;
  logic [WR_W-1:0]   data_q;
  logic              accept, last_accept, xfer;

  vec_lane_narrow #(.LANES(LANES), .ELEM_W(ELEM_W)) u_lo (
    .wide_data(bus.res_data), .hi(1'b0), .narrow_data(res_lo)
  );
  vec_lane_narrow #(.LANES(LANES), .ELEM_W(ELEM_W)) u_hi (
    .wide_data(bus.res_data), .hi(1'b1), .narrow_data(res_hi)
  );

  always_comb begin
    accept      = (state != IDLE) && !bus.wr_stall;
    last_accept = accept && ((state == WR_HI) || !wide_q);
    xfer        = bus.res_valid && ((state == IDLE) || last_accept);
    state_nxt   = state;
    case (state)
      IDLE:    if (xfer) state_nxt = WR_LO;
      WR_LO:   if (accept) state_nxt = wide_q ? WR_HI : (xfer ? WR_LO : IDLE);
      WR_HI:   if (accept) state_nxt = xfer ? WR_LO : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Only the high halves are kept; the low halves go straight into the write register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      hi_q   <= '0;
      wide_q <= 1'b0;
    end else if (xfer) begin
      addr_q <= bus.res_dest;
      data_q <= res_lo;
      hi_q   <= res_hi;
      wide_q <= bus.res_wide;
    end else if ((state == WR_LO) && accept && wide_q) begin
      addr_q <= addr_q + 1'b1;
      data_q <= hi_q;
    end
  end

  assign bus.wr_en     = (state != IDLE);
  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = data_q;
  assign bus.done      = last_accept;
  assign bus.res_ready = (state == IDLE) || last_accept;
endmodule

// File: tb/tb_vec_result_writeback.sv
// tb/tb_vec_result_writeback.sv - scoreboard bench for vec_result_writeback
module tb_vec_result_writeback;
  import vec_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vec_result_writeback_if bus ();
  vec_result_writeback dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [1:0]      addr;
    logic [WR_W-1:0] data;
    logic            done;
  } exp_t;

  exp_t sb[$];
  int   acc_cyc[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_i(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [WR_W-1:0] act, input logic [WR_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [WR_W-1:0] lanes(input logic [31:0] base, input logic [31:0] step);
    logic [WR_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[32*i +: 32] = base + step * 32'(i);
    return r;
  endfunction

  function automatic logic [RES_W-1:0] mk(input logic [31:0] hib, input logic [31:0] hstep,
                                          input logic [31:0] lob, input logic [31:0] lstep);
    logic [RES_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[64*i +: 64] = {hib + hstep * 32'(i), lob + lstep * 32'(i)};
    return r;
  endfunction

  // Monitor: every accepted write is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en && !bus.wr_stall) begin
        acc_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk_i("unexpected_write_addr", int'(bus.wr_addr), -1);
        end else begin
          e = sb.pop_front();
          chk_i("wr_addr", int'(bus.wr_addr), int'(e.addr));
          chk_w("wr_data", bus.wr_data, e.data);
          chk_i("done", int'(bus.done), int'(e.done));
        end
      end else if (bus.done) begin
        chk_i("done_without_write", 1, 0);
      end
    end
  end

  task automatic send(input logic [RES_W-1:0] d, input logic [1:0] dest, input logic wide,
                      input logic [WR_W-1:0] exp_lo, input logic [WR_W-1:0] exp_hi,
                      input logic [1:0] hi_addr, output int waits, output int tc);
    exp_t x;
    bus.res_valid = 1'b1;
    bus.res_data  = d;
    bus.res_dest  = dest;
    bus.res_wide  = wide;
    waits = 0;
    @(negedge clk);
    while (!bus.res_ready && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.res_ready) chk_i("send_ready_timeout", 0, 1);
    tc = cyc;
    x.addr = dest; x.data = exp_lo; x.done = !wide;
    sb.push_back(x);
    if (wide) begin
      x.addr = hi_addr; x.data = exp_hi; x.done = 1'b1;
      sb.push_back(x);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk_i("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w, tc, n0;
    int nw[6];
    int ntc;
    rst_n         = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.res_dest  = '0;
    bus.res_wide  = 1'b0;
    bus.wr_stall  = 1'b0;
    #2;
    chk_i("rst_wr_en", int'(bus.wr_en), 0);
    chk_i("rst_wr_addr", int'(bus.wr_addr), 0);
    chk_w("rst_wr_data", bus.wr_data, '0);
    chk_i("rst_done", int'(bus.done), 0);
    chk_i("rst_res_ready", int'(bus.res_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Wide single result, dest 1
    n0 = acc_cyc.size();
    send(mk(32'h1000, 1, 32'h2000, 1), 2'd1, 1'b1, lanes(32'h2000, 1), lanes(32'h1000, 1), 2'd2, w, tc);
    bus.res_valid = 1'b0;
    drain();
    chk_i("wide_write_count", acc_cyc.size() - n0, 2);
    chk_i("wide_lo_cycle", acc_cyc[n0] - tc, 1);
    chk_i("wide_hi_cycle", acc_cyc[n0+1] - tc, 2);

    // Narrow result, dest 3
    n0 = acc_cyc.size();
    send(mk(32'hFFFF_FFFF, 0, 32'h0, 1), 2'd3, 1'b0, lanes(32'h0, 1), '0, 2'd0, w, tc);
    bus.res_valid = 1'b0;
    drain();
    chk_i("narrow_write_count", acc_cyc.size() - n0, 1);
    chk_i("narrow_cycle", acc_cyc[n0] - tc, 1);

    // Address wrap
    send(mk(32'hA000, 1, 32'hB000, 1), 2'd3, 1'b1, lanes(32'hB000, 1), lanes(32'hA000, 1), 2'd0, w, tc);
    bus.res_valid = 1'b0;
    drain();

    // Stall for 3 cycles during the high write
    send(mk(32'hC000, 1, 32'hD000, 1), 2'd0, 1'b1, lanes(32'hD000, 1), lanes(32'hC000, 1), 2'd1, w, tc);
    bus.res_valid = 1'b0;
    @(posedge clk); #1;
    bus.wr_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_i("stall_wr_en", int'(bus.wr_en), 1);
      chk_i("stall_wr_addr", int'(bus.wr_addr), 1);
      chk_w("stall_wr_data", bus.wr_data, lanes(32'hC000, 1));
      chk_i("stall_res_ready", int'(bus.res_ready), 0);
      chk_i("stall_done", int'(bus.done), 0);
      @(posedge clk); #1;
    end
    bus.wr_stall = 1'b0;
    @(negedge clk);
    chk_i("unstall_res_ready", int'(bus.res_ready), 1);
    drain();

    // Back-to-back: 4 narrow then 2 wide
    n0 = acc_cyc.size();
    for (int k = 0; k < 4; k++) begin
      send(mk(32'hEEEE_0000, 0, 32'h100 * 32'(k + 1), 1), 2'(k), 1'b0,
           lanes(32'h100 * 32'(k + 1), 1), '0, 2'd0, nw[k], ntc);
    end
    send(mk(32'h7000, 1, 32'h6000, 1), 2'd2, 1'b1, lanes(32'h6000, 1), lanes(32'h7000, 1), 2'd3, nw[4], ntc);
    send(mk(32'h9000, 1, 32'h8000, 1), 2'd1, 1'b1, lanes(32'h8000, 1), lanes(32'h9000, 1), 2'd2, nw[5], ntc);
    bus.res_valid = 1'b0;
    drain();
    for (int k = 0; k < 5; k++) chk_i("b2b_wait", nw[k], 0);
    chk_i("b2b_wide2_wait", nw[5], 1);
    chk_i("b2b_write_count", acc_cyc.size() - n0, 8);
    for (int k = 1; k < 8; k++) chk_i("b2b_gap", acc_cyc[n0+k] - acc_cyc[n0+k-1], 1);

    // Reset in the middle of the low write of a wide result
    send(mk(32'h3000, 1, 32'h4000, 1), 2'd1, 1'b1, lanes(32'h4000, 1), lanes(32'h3000, 1), 2'd2, w, tc);
    bus.res_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_i("midrst_wr_en", int'(bus.wr_en), 0);
    chk_i("midrst_wr_addr", int'(bus.wr_addr), 0);
    chk_i("midrst_done", int'(bus.done), 0);
    chk_i("midrst_res_ready", int'(bus.res_ready), 1);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_i("post_rst_res_ready", int'(bus.res_ready), 1);
    chk_i("post_rst_wr_en", int'(bus.wr_en), 0);
    @(posedge clk); #1;
    n0 = acc_cyc.size();
    send(mk(32'h5A00, 1, 32'h6B00, 1), 2'd2, 1'b1, lanes(32'h6B00, 1), lanes(32'h5A00, 1), 2'd3, w, tc);
    bus.res_valid = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    chk_i("post_rst_write_count", acc_cyc.size() - n0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
